// File: rtl/geofence_pkg.sv
// rtl/geofence_pkg.sv - shared constants and launch FSM encoding for the geofence path
package geofence_pkg;

    localparam int COORD_W = 10;
    localparam int NUM_PTS = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESULT = 2'd3
    } state_e;

endpackage

// File: rtl/geofence_frame_buf.sv
// rtl/geofence_frame_buf.sv - two-slot point frame buffer with framing checks and replay pointer
module geofence_frame_buf
    import geofence_pkg::*;
#(
    parameter int W = geofence_pkg::COORD_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_valid_i,
    input  logic [W-1:0] wr_x_i,
    input  logic [W-1:0] wr_y_i,
    input  logic         wr_last_i,
    output logic         wr_ready_o,
    output logic         frame_err_o,
    input  logic         rd_adv_i,
    output logic         rd_full_o,
    output logic         rd_last_o,
    output logic [W-1:0] rd_x_o,
    output logic [W-1:0] rd_y_o
);

    localparam int IW = $clog2(NUM_PTS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_PTS - 1);

    logic [W-1:0]  mem_x_q [2][NUM_PTS];
    logic [W-1:0]  mem_y_q [2][NUM_PTS];
    logic [1:0]    full_q, full_d;
    logic          wr_slot_q, rd_slot_q;
    logic [IW-1:0] wr_idx_q, rd_idx_q;
    logic          drop_q, en_q, err_q;
    logic          accept, wr_end, rd_end;

    assign wr_ready_o  = en_q & ~full_q[wr_slot_q];
    assign accept      = wr_valid_i & wr_ready_o;
    assign wr_end      = accept & ~drop_q & (wr_idx_q == LAST_IDX) & wr_last_i;
    assign rd_end      = rd_adv_i & (rd_idx_q == LAST_IDX);
    assign rd_full_o   = full_q[rd_slot_q];
    assign rd_last_o   = (rd_idx_q == LAST_IDX);
    assign rd_x_o      = mem_x_q[rd_slot_q][rd_idx_q];
    assign rd_y_o      = mem_y_q[rd_slot_q][rd_idx_q];
    assign frame_err_o = err_q;

    // Load and replay always target different slots, so set and clear never collide.
    always_comb begin
        full_d = full_q;
        if (rd_end) full_d[rd_slot_q] = 1'b0;
        if (wr_end) full_d[wr_slot_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (accept && !drop_q) begin
            mem_x_q[wr_slot_q][wr_idx_q] <= wr_x_i;
            mem_y_q[wr_slot_q][wr_idx_q] <= wr_y_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q    <= '0;
            wr_slot_q <= 1'b0;
            rd_slot_q <= 1'b0;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            drop_q    <= 1'b0;
            en_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            en_q   <= 1'b1;
            full_q <= full_d;
            if (accept) begin
                if (drop_q) begin
                    // Overlong frame: swallow points through the next in_last.
                    if (wr_last_i) drop_q <= 1'b0;
                end else if (wr_idx_q == LAST_IDX) begin
                    wr_idx_q <= '0;
                    if (wr_last_i) begin
                        wr_slot_q <= ~wr_slot_q;
                    end else begin
                        err_q  <= 1'b1;
                        drop_q <= 1'b1;
                    end
                end else if (wr_last_i) begin
                    err_q    <= 1'b1;
                    wr_idx_q <= '0;
                end else begin
                    wr_idx_q <= wr_idx_q + 1'b1;
                end
            end
            if (rd_adv_i) begin
                rd_idx_q <= rd_end ? '0 : rd_idx_q + 1'b1;
                if (rd_end) rd_slot_q <= ~rd_slot_q;
            end
        end
    end

endmodule

// File: rtl/geofence_feeder.sv
// rtl/geofence_feeder.sv - frames points, replays them into the geofence checker, returns tagged verdicts
module geofence_feeder
    import geofence_pkg::*;
#(
    parameter int COORD_W = geofence_pkg::COORD_W,
    parameter int ID_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    input  logic               in_last,
    output logic               gf_hold,
    output logic [COORD_W-1:0] gf_x,
    output logic [COORD_W-1:0] gf_y,
    input  logic               gf_valid,
    input  logic               gf_inside,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_inside,
    output logic               res_timeout,
    output logic [ID_W-1:0]    res_id,
    output logic               frame_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    logic               hold_q, hold_d;
    logic [COORD_W-1:0] gx_q, gx_d, gy_q, gy_d;
    logic               rv_q, rv_d, rin_q, rin_d, rto_q, rto_d;
    logic [ID_W-1:0]    rid_q, rid_d, id_q, id_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               rd_adv, rd_full, rd_last;
    logic [COORD_W-1:0] rd_x, rd_y;

    geofence_frame_buf #(.W(COORD_W)) u_buf (
        .clk         (clk),
        .reset       (reset),
        .wr_valid_i  (in_valid),
        .wr_x_i      (in_x),
        .wr_y_i      (in_y),
        .wr_last_i   (in_last),
        .wr_ready_o  (in_ready),
        .frame_err_o (frame_err),
        .rd_adv_i    (rd_adv),
        .rd_full_o   (rd_full),
        .rd_last_o   (rd_last),
        .rd_x_o      (rd_x),
        .rd_y_o      (rd_y)
    );

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        gx_d    = gx_q;
        gy_d    = gy_q;
        rv_d    = rv_q;
        rin_d   = rin_q;
        rto_d   = rto_q;
        rid_d   = rid_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        rd_adv  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_full && !rv_q) begin
                    hold_d  = 1'b0;
                    gx_d    = rd_x;
                    gy_d    = rd_y;
                    rd_adv  = 1'b1;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                gx_d   = rd_x;
                gy_d   = rd_y;
                rd_adv = 1'b1;
                if (rd_last) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A checker answer on the final cycle wins over the timeout.
                if (gf_valid || cnt_d == CW'(TIMEOUT)) begin
                    rin_d   = gf_valid & gf_inside;
                    rto_d   = ~gf_valid;
                    rid_d   = id_q;
                    rv_d    = 1'b1;
                    id_d    = id_q + 1'b1;
                    hold_d  = 1'b1;
                    state_d = RESULT;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    rv_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            hold_q  <= 1'b1;
            gx_q    <= '0;
            gy_q    <= '0;
            rv_q    <= 1'b0;
            rin_q   <= 1'b0;
            rto_q   <= 1'b0;
            rid_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            gx_q    <= gx_d;
            gy_q    <= gy_d;
            rv_q    <= rv_d;
            rin_q   <= rin_d;
            rto_q   <= rto_d;
            rid_q   <= rid_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gf_hold     = hold_q;
    assign gf_x        = gx_q;
    assign gf_y        = gy_q;
    assign res_valid   = rv_q;
    assign res_inside  = rin_q;
    assign res_timeout = rto_q;
    assign res_id      = rid_q;

endmodule

// File: tb/tb_geofence_feeder.sv
// tb/tb_geofence_feeder.sv - directed vector bench for geofence_feeder with a stub checker
module tb_geofence_feeder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [9:0] in_x = '0;
    logic [9:0] in_y = '0;
    logic       in_last = 1'b0;
    logic       gf_hold;
    logic [9:0] gf_x, gf_y;
    logic       gf_valid = 1'b0;
    logic       gf_inside = 1'b0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic       res_inside, res_timeout;
    logic [7:0] res_id;
    logic       frame_err;

    always #5 clk = ~clk;

    geofence_feeder #(.COORD_W(10), .ID_W(8), .TIMEOUT(255)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_last     (in_last),
        .gf_hold     (gf_hold),
        .gf_x        (gf_x),
        .gf_y        (gf_y),
        .gf_valid    (gf_valid),
        .gf_inside   (gf_inside),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_inside  (res_inside),
        .res_timeout (res_timeout),
        .res_id      (res_id),
        .frame_err   (frame_err)
    );

    typedef struct packed {
        logic [6:0][9:0] x;
        logic [6:0][9:0] y;
        logic            exp_inside;
    } frame_t;

    frame_t     tbl [3];
    int         tests = 0;
    int         fails = 0;
    logic       stub_en = 1'b1;
    logic [9:0] sx [7];
    logic [9:0] sy [7];
    int         scnt = 0;
    int         dly = 0;

    function automatic logic bbox_inside();
        int minx = 1023, maxx = 0, miny = 1023, maxy = 0;
        for (int i = 1; i < 7; i++) begin
            if (int'(sx[i]) < minx) minx = int'(sx[i]);
            if (int'(sx[i]) > maxx) maxx = int'(sx[i]);
            if (int'(sy[i]) < miny) miny = int'(sy[i]);
            if (int'(sy[i]) > maxy) maxy = int'(sy[i]);
        end
        return (int'(sx[0]) >= minx) && (int'(sx[0]) <= maxx) &&
               (int'(sy[0]) >= miny) && (int'(sy[0]) <= maxy);
    endfunction

    // Stub checker: records the replayed points, answers two cycles after the seventh.
    always @(negedge clk) begin
        gf_valid = 1'b0;
        if (gf_hold) begin
            scnt = 0;
            dly  = 0;
        end else if (scnt < 7) begin
            sx[scnt] = gf_x;
            sy[scnt] = gf_y;
            scnt++;
        end else if (stub_en) begin
            dly++;
            if (dly == 2) begin
                gf_inside = bbox_inside();
                gf_valid  = 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic send_pt(input logic [9:0] x, input logic [9:0] y, input logic last);
        int n = 0;
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_pt: in_ready stuck at 0 expected 1");
        end else begin
            in_valid = 1'b1;
            in_x     = x;
            in_y     = y;
            in_last  = last;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic send_frame(input int f, input int last_at);
        for (int i = 0; i < 7; i++) begin
            if (i > last_at) break;
            send_pt(tbl[f].x[i], tbl[f].y[i], i == last_at);
        end
    endtask

    task automatic check_result(input string nm, input logic ins, input logic tmo, input logic [7:0] id);
        int n = 0;
        res_ready = 1'b1;
        while (!res_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid) begin
            tests++;
            fails++;
            $display("FAIL %s: res_valid stuck at 0 expected 1", nm);
        end else begin
            chk({nm, "_inside"}, 32'(res_inside), 32'(ins));
            chk({nm, "_timeout"}, 32'(res_timeout), 32'(tmo));
            chk({nm, "_id"}, 32'(res_id), 32'(id));
            @(posedge clk);
            @(negedge clk);
        end
        res_ready = 1'b0;
    endtask

    task automatic check_replay(input string nm, input int f);
        logic ok = 1'b1;
        for (int i = 0; i < 7; i++)
            if (sx[i] !== tbl[f].x[i] || sy[i] !== tbl[f].y[i]) ok = 1'b0;
        chk(nm, 32'(ok), 32'd1);
    endtask

    task automatic wait_launch(output int ok);
        int n = 0;
        while (gf_hold && n < 1000) begin
            @(negedge clk);
            n++;
        end
        ok = gf_hold ? 0 : 1;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL wait_launch: gf_hold stuck at 1 expected 0");
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        res_ready = 1'b0;
        stub_en   = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rxs[6] = '{25, 100, 25, 0, 75, 75};
        int rys[6] = '{93, 50, 7, 50, 7, 93};
        int txs[3] = '{50, 500, 40};
        int tys[3] = '{50, 500, 30};
        logic exi[3] = '{1'b1, 1'b0, 1'b1};
        int ok;
        int n;

        for (int f = 0; f < 3; f++) begin
            tbl[f].x[0]       = 10'(txs[f]);
            tbl[f].y[0]       = 10'(tys[f]);
            tbl[f].exp_inside = exi[f];
            for (int i = 0; i < 6; i++) begin
                tbl[f].x[i+1] = 10'(rxs[i]);
                tbl[f].y[i+1] = 10'(rys[i]);
            end
        end

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_gf_hold", 32'(gf_hold), 32'd1);
        chk("rst_gf_x", 32'(gf_x), 32'd0);
        chk("rst_gf_y", 32'(gf_y), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_inside", 32'(res_inside), 32'd0);
        chk("rst_res_timeout", 32'(res_timeout), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("in_ready_after_release", 32'(in_ready), 32'd1);

        for (int f = 0; f < 3; f++) begin
            send_frame(f, 6);
            check_result($sformatf("frame%0d", f), tbl[f].exp_inside, 1'b0, 8'(f));
            check_replay($sformatf("frame%0d_replay", f), f);
        end

        // Three frames back to back while the result port is stalled.
        do_reset();
        for (int f = 0; f < 3; f++) send_frame(f, 6);
        repeat (20) @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_res_valid", 32'(res_valid), 32'd1);
        repeat (300) @(negedge clk);
        chk("stall_hold_valid", 32'(res_valid), 32'd1);
        chk("stall_hold_id", 32'(res_id), 32'd0);
        chk("stall_hold_inside", 32'(res_inside), 32'd1);
        for (int f = 0; f < 3; f++)
            check_result($sformatf("stream%0d", f), tbl[f].exp_inside, 1'b0, 8'(f));

        // Short frame, then overlong frame, each followed by a good one.
        do_reset();
        send_frame(0, 3);
        chk("short_frame_err", 32'(frame_err), 32'd1);
        send_frame(2, 6);
        check_result("after_short", 1'b1, 1'b0, 8'd0);
        repeat (50) @(negedge clk);
        chk("short_no_extra", 32'(res_valid), 32'd0);
        send_frame(0, 7);
        send_pt(10'd1, 10'd1, 1'b0);
        send_pt(10'd2, 10'd2, 1'b1);
        send_frame(1, 6);
        check_result("after_long", 1'b0, 1'b0, 8'd1);
        check_replay("after_long_replay", 1);
        chk("long_frame_err", 32'(frame_err), 32'd1);

        // Checker never answers.
        do_reset();
        stub_en = 1'b0;
        send_frame(0, 6);
        wait_launch(ok);
        n = 0;
        if (ok != 0) begin
            while (!res_valid && n < 400) begin
                @(negedge clk);
                n++;
            end
            chk("timeout_latency", 32'(n), 32'd261);
            chk("timeout_gf_hold", 32'(gf_hold), 32'd1);
            check_result("timeout", 1'b0, 1'b1, 8'd0);
        end
        stub_en = 1'b1;

        // Reset while point 3 is on the checker bus.
        do_reset();
        send_frame(0, 6);
        wait_launch(ok);
        if (ok != 0) begin
            repeat (3) @(negedge clk);
            chk("midreset_pt3_x", 32'(gf_x), 32'd25);
            reset = 1'b0;
            #1;
            chk("midreset_gf_hold", 32'(gf_hold), 32'd1);
            chk("midreset_res_valid", 32'(res_valid), 32'd0);
            chk("midreset_in_ready", 32'(in_ready), 32'd0);
            chk("midreset_gf_x", 32'(gf_x), 32'd0);
            repeat (2) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            send_frame(1, 6);
            check_result("post_reset", 1'b0, 1'b0, 8'd0);
            check_replay("post_reset_replay", 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/geofence_feeder.md
Name: geofence_feeder

Overview:
- Upstream stage of the geofence checker.
- Accepts coordinate points from a valid/ready stream. Assembles them into 7-point frames: the target first, then six fence receivers.
- Double-buffers the frames, replays each frame into the checker on 7 back-to-back cycles, and waits for the checker's one-cycle valid pulse.
- Returns the inside/outside verdict, tagged with a frame ID, on a valid/ready result port.

Parameters:
- COORD_W, 10, coordinate width; must match checker X/Y.
- ID_W, 8, frame ID counter width; wraps modulo 2^ID_W.
- TIMEOUT, 255, max cycles from last replayed point to checker valid before abort.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- in_valid  in  1  upstream point valid
- in_ready  out  1  feeder can accept point
- in_x  in  COORD_W  point X
- in_y  in  COORD_W  point Y
- in_last  in  1  marks 7th point of a frame
- gf_hold  out  1  drives checker's active-high reset; high keeps checker idle
- gf_x  out  COORD_W  to checker X
- gf_y  out  COORD_W  to checker Y
- gf_valid  in  1  checker result pulse
- gf_inside  in  1  checker is_inside
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- res_inside  out  1  verdict (0 when res_timeout=1)
- res_timeout  out  1  checker did not answer within TIMEOUT
- res_id  out  ID_W  frame ID, counts launched frames from 0
- frame_err  out  1  sticky framing error, cleared only by reset

Behaviour:
Reset values:
- in_ready=0, gf_hold=1, gf_x=gf_y=0.
- res_valid=0, res_inside=0, res_timeout=0, res_id=0, frame_err=0.
- Both buffer slots empty, write index 0, ID counter 0.
- in_ready rises the first cycle after reset is released.

Load side:
- Two slots of 7 entries each. A point is accepted when in_valid and in_ready are both high. in_ready=1 iff the current write slot is not full.
- Point with index 6 and in_last=1: the slot is marked full and writing toggles to the other slot.
- in_last=1 at index <6: frame_err=1, the partial frame is discarded, the write index resets to 0, and the slot stays empty.
- Index 6 with in_last=0: frame_err=1, the partial frame is discarded. Points keep being accepted and dropped up to and including the next in_last=1; the next frame then starts at index 0.
- A slot becomes free the cycle after its 7th point is replayed. Load and replay may run on different slots in the same cycle.

Launch FSM:
- IDLE: gf_hold=1. Go to LAUNCH when the read slot is full and res_valid=0.
  - At that edge: gf_hold<=0, gf_x/gf_y<=point0.
- LAUNCH: on each edge, drive the next point. Points 1..6 appear on the 6 cycles after point0, so the checker samples point k at edge E+1+k.
  - After point6 is driven: free the slot, toggle the read slot, clear the timeout counter, go to WAIT.
- WAIT: the counter increments every cycle.
  - gf_valid=1: res_inside<=gf_inside, res_timeout<=0, res_id<=ID counter, res_valid<=1, ID counter +1, gf_hold<=1, go to RESULT.
  - Counter reaches TIMEOUT first: same captures, but with res_inside<=0 and res_timeout<=1; gf_hold<=1; go to RESULT.
  - gf_valid arriving in IDLE or LAUNCH is ignored.
- RESULT: hold res_* stable while res_valid=1 and res_ready=0.
  - On res_valid and res_ready both high, res_valid<=0 and go to IDLE.
  - Minimum gf_hold assertion between frames: 1 cycle.

Boundary conditions:
- A result accepted and the next slot already full: IDLE launches on the following edge.
- Reset asserted mid-frame: everything returns to reset values at once and buffered points are lost.
- Both slots full: in_ready=0. in_x, in_y and in_last are ignored while in_ready=0.

Decomposition:
- Shared package geofence_pkg holds:
  - COORD_W and NUM_PTS=7 (shared with the checker);
  - the FSM state encoding IDLE/LAUNCH/WAIT/RESULT.
- One sub-module, geofence_frame_buf: 2x7 register file with write-slot/index and read-slot/index pointers, full flags, and discard control.

Test Plan:
- Frame T(50,50), R(100,50),(75,93),(25,93),(0,50),(25,7),(75,7), in shuffled order after T, res_ready=1 -> gf_x/gf_y replay 7 back-to-back cycles; res_valid with res_inside=1, res_timeout=0, res_id=0.
- Same receivers, T=(500,500) -> res_inside=0, res_id=1.
- Three frames streamed with no gaps and res_ready=0 for 300 cycles -> in_ready=0 after both slots fill; res_id=0 held stable; after release, ids 1 and 2 follow in order.
- Frame with in_last on the 4th point, then a valid frame -> frame_err=1; only one result, res_id=0, verdict from the valid frame.
- Stub checker that never pulses gf_valid -> after 255 WAIT cycles, res_valid=1, res_timeout=1, res_inside=0, gf_hold=1.
- Reset pulled low during LAUNCH of point 3 -> gf_hold=1, res_valid=0, in_ready=0 immediately; after release, the next full frame gets res_id=0.
